// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - hardwired fetch/decode/execute control FSM for the phase-1 DataPath
//
// Moore control unit. It fetches each instruction, decodes the register-format
// ALU opcodes, then sequences execute and write-back by driving the DataPath strobes.
// Ports:
//   Clock, Clear           clock; asynchronous active-high reset
//   Run                    1 = keep executing, 0 = stop at the next instruction boundary
//   MemDone                memory read data valid (sampled in T1)
//   IR[31:0]               instruction register contents from DataPath
//   PCout..LOin            single-bit datapath strobes
//   Rout[15:0], Rin[15:0]  one-hot register bus-out / bus-in selects
//   AluOp[12:0]            one-hot {ADD,SUB,SHR,SHRA,SHL,ROR,ROL,AND,OR,MUL,DIV,NEG,NOT}
//   Done, Halted, Illegal  status; MemTimeout is sticky until Clear
module alu_instr_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic        MemDone,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [12:0] AluOp,
    output logic        Done,
    output logic        Halted,
    output logic        Illegal,
    output logic        MemTimeout
);

    localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [12:0] OP_ADD  = 13'h1000;
    localparam logic [12:0] OP_SUB  = 13'h0800;
    localparam logic [12:0] OP_SHR  = 13'h0400;
    localparam logic [12:0] OP_SHRA = 13'h0200;
    localparam logic [12:0] OP_SHL  = 13'h0100;
    localparam logic [12:0] OP_ROR  = 13'h0080;
    localparam logic [12:0] OP_ROL  = 13'h0040;
    localparam logic [12:0] OP_AND  = 13'h0020;
    localparam logic [12:0] OP_OR   = 13'h0010;
    localparam logic [12:0] OP_MUL  = 13'h0008;
    localparam logic [12:0] OP_DIV  = 13'h0004;
    localparam logic [12:0] OP_NEG  = 13'h0002;
    localparam logic [12:0] OP_NOT  = 13'h0001;

    state_t           state, state_nxt;
    logic [WCW-1:0]   wait_cnt;
    logic             mem_timeout;
    logic             wait_hit;

    logic [4:0]       opcode;
    logic [3:0]       ra, rb, rc;
    logic [12:0]      alu_sel;
    logic             is_alu, is_unary, is_muldiv, is_nop, is_halt;
    logic             unused_ir_bits;

    assign opcode         = IR[31:27];
    assign ra             = IR[26:23];
    assign rb             = IR[22:19];
    assign rc             = IR[18:15];
    assign unused_ir_bits = ^IR[14:0];

    // Instruction decode; only meaningful from T3 onward, once IR holds the fetched word.
    always_comb begin
        alu_sel   = '0;
        is_alu    = 1'b1;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            5'b00011: alu_sel = OP_ADD;
            5'b00100: alu_sel = OP_SUB;
            5'b00101: alu_sel = OP_AND;
            5'b00110: alu_sel = OP_OR;
            5'b00111: alu_sel = OP_SHR;
            5'b01000: alu_sel = OP_SHRA;
            5'b01001: alu_sel = OP_SHL;
            5'b01010: alu_sel = OP_ROR;
            5'b01011: alu_sel = OP_ROL;
            5'b01111: begin alu_sel = OP_MUL; is_muldiv = 1'b1; end
            5'b10000: begin alu_sel = OP_DIV; is_muldiv = 1'b1; end
            5'b10001: begin alu_sel = OP_NEG; is_unary  = 1'b1; end
            5'b10010: begin alu_sel = OP_NOT; is_unary  = 1'b1; end
            5'b11010: begin is_alu = 1'b0; is_nop  = 1'b1; end
            5'b11011: begin is_alu = 1'b0; is_halt = 1'b1; end
            default:  is_alu = 1'b0;
        endcase
    end

    // Last allowed stalled T1 cycle: the counter already holds MEM_WAIT_MAX-1 stalls.
    assign wait_hit = (wait_cnt == WCW'(MEM_WAIT_MAX - 1));

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_T1 && !MemDone) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_hit)
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        Read      = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zhighout  = 1'b0;
        Zlowout   = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rout      = '0;
        Rin       = '0;
        AluOp     = '0;
        Done      = 1'b0;
        Illegal   = 1'b0;
        Halted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Run)
                    state_nxt = S_T0;
            end
            S_T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                // PCin repeats while stalled; Z still holds PC+1 so it is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (MemDone)
                    state_nxt = S_T2;
                else if (wait_hit)
                    state_nxt = S_HALT;
            end
            S_T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else if (is_nop) begin
                    Done      = 1'b1;
                    state_nxt = Run ? S_T0 : S_IDLE;
                end else if (!is_alu) begin
                    Illegal   = 1'b1;
                    Done      = 1'b1;
                    state_nxt = Run ? S_T0 : S_IDLE;
                end else if (is_unary) begin
                    Rout      = 16'd1 << rb;
                    AluOp     = alu_sel;
                    Zin       = 1'b1;
                    state_nxt = S_T5;
                end else begin
                    Rout      = 16'd1 << rb;
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end
            end
            S_T4: begin
                Rout      = 16'd1 << rc;
                AluOp     = alu_sel;
                Zin       = 1'b1;
                state_nxt = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin      = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    Rin       = 16'd1 << ra;
                    Done      = 1'b1;
                    state_nxt = Run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                Done      = 1'b1;
                state_nxt = Run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign MemTimeout = mem_timeout;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - self-checking bench for alu_instr_sequencer
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic [17:0] s;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [12:0] alu;
    } ov_t;

    localparam logic [17:0] PCOUT = 18'h1 << 17, PCIN = 18'h1 << 16, INCPC = 18'h1 << 15;
    localparam logic [17:0] MARIN = 18'h1 << 14, MDRIN = 18'h1 << 13, MDROUT = 18'h1 << 12;
    localparam logic [17:0] READ = 18'h1 << 11, IRIN = 18'h1 << 10, YIN = 18'h1 << 9;
    localparam logic [17:0] ZIN = 18'h1 << 8, ZHI = 18'h1 << 7, ZLO = 18'h1 << 6;
    localparam logic [17:0] HIIN = 18'h1 << 5, LOIN = 18'h1 << 4, DONE = 18'h1 << 3;
    localparam logic [17:0] HALTED = 18'h1 << 2, ILL = 18'h1 << 1, MTO = 18'h1;

    localparam logic [12:0] A_AND = 13'h0020, A_MUL = 13'h0008, A_NEG = 13'h0002;

    localparam logic [31:0] I_AND  = 32'h2918_0000;
    localparam logic [31:0] I_MUL  = 32'h7910_0000;
    localparam logic [31:0] I_NEG  = 32'h8A18_0000;
    localparam logic [31:0] I_ILL  = 32'hF800_0000;
    localparam logic [31:0] I_NOP  = 32'hD000_0000;
    localparam logic [31:0] I_HALT = 32'hD800_0000;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Run = 1'b0;
    logic        MemDone = 1'b0;
    logic [31:0] IR = '0;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic [12:0] AluOp;
    logic        Done, Halted, Illegal, MemTimeout;

    int n_tests = 0;
    int n_fail  = 0;

    ov_t   exp_q[$];
    string tag_q[$];
    ov_t   obs;
    ov_t   zero_v;
    ov_t   e_t0, e_t1, e_t2;

    alu_instr_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemDone(MemDone), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
        .Rout(Rout), .Rin(Rin), .AluOp(AluOp), .Done(Done), .Halted(Halted),
        .Illegal(Illegal), .MemTimeout(MemTimeout)
    );

    always #5 Clock = ~Clock;

    assign obs = '{s: {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
                       Zhighout, Zlowout, HIin, LOin, Done, Halted, Illegal, MemTimeout},
                   rout: Rout, rin: Rin, alu: AluOp};

    function automatic ov_t mk(logic [17:0] s, logic [15:0] ro, logic [15:0] ri, logic [12:0] a);
        ov_t v;
        v.s = s; v.rout = ro; v.rin = ri; v.alu = a;
        return v;
    endfunction

    task automatic chk(string tag, ov_t o, ov_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed s=%h rout=%h rin=%h alu=%h, expected s=%h rout=%h rin=%h alu=%h",
                   tag, o.s, o.rout, o.rin, o.alu, e.s, e.rout, e.rin, e.alu);
        end
    endtask

    // Scoreboard drain: one expectation per cycle, compared mid-cycle.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            ov_t   e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, obs, e);
        end
    end

    // Push the expectation for the current cycle, then advance one clock.
    task automatic cyc(string tag, ov_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(string tag);
        cyc({tag, "_t0"}, e_t0);
        cyc({tag, "_t1"}, e_t1);
        cyc({tag, "_t2"}, e_t2);
    endtask

    initial begin
        zero_v = '0;
        e_t0 = mk(PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 13'h0);
        e_t1 = mk(ZLO | PCIN | READ | MDRIN, 16'h0, 16'h0, 13'h0);
        e_t2 = mk(MDROUT | IRIN, 16'h0, 16'h0, 13'h0);

        @(posedge Clock);
        #1;
        cyc("reset", zero_v);
        Clear = 1'b0;
        cyc("idle_run0_a", zero_v);
        cyc("idle_run0_b", zero_v);
        Run = 1'b1;
        MemDone = 1'b1;
        cyc("idle_run1", zero_v);

        // AND R2,R3,R0
        IR = I_AND;
        fetch("and");
        cyc("and_t3", mk(YIN, 16'h0008, 16'h0, 13'h0));
        cyc("and_t4", mk(ZIN, 16'h0001, 16'h0, A_AND));
        cyc("and_t5", mk(ZLO | DONE, 16'h0, 16'h0004, 13'h0));

        // Clear mid-T4 with Run=1: immediate IDLE, then a fresh fetch
        fetch("clr");
        cyc("clr_t3", mk(YIN, 16'h0008, 16'h0, 13'h0));
        exp_q.push_back(mk(ZIN, 16'h0001, 16'h0, A_AND));
        tag_q.push_back("clr_t4");
        @(negedge Clock);
        #1;
        Clear = 1'b1;
        #1;
        chk("clr_async", obs, zero_v);
        @(posedge Clock);
        #1;
        cyc("clr_hold", zero_v);
        Clear = 1'b0;
        cyc("clr_idle", zero_v);

        // MUL R2,R2 with MemDone arriving after 3 stalled cycles
        MemDone = 1'b0;
        IR = I_MUL;
        cyc("mul_t0", e_t0);
        cyc("mul_t1_w1", e_t1);
        cyc("mul_t1_w2", e_t1);
        cyc("mul_t1_w3", e_t1);
        MemDone = 1'b1;
        cyc("mul_t1_w4", e_t1);
        cyc("mul_t2", e_t2);
        cyc("mul_t3", mk(YIN, 16'h0004, 16'h0, 13'h0));
        cyc("mul_t4", mk(ZIN, 16'h0001, 16'h0, A_MUL));
        cyc("mul_t5", mk(ZLO | LOIN, 16'h0, 16'h0, 13'h0));
        cyc("mul_t6", mk(ZHI | HIIN | DONE, 16'h0, 16'h0, 13'h0));

        // NEG R4,R3 with Run dropped mid-instruction
        IR = I_NEG;
        cyc("neg_t0", e_t0);
        cyc("neg_t1", e_t1);
        Run = 1'b0;
        cyc("neg_t2", e_t2);
        cyc("neg_t3", mk(ZIN, 16'h0008, 16'h0, A_NEG));
        cyc("neg_t5", mk(ZLO | DONE, 16'h0, 16'h0010, 13'h0));
        cyc("stop_idle_a", zero_v);
        cyc("stop_idle_b", zero_v);
        Run = 1'b1;
        cyc("restart_idle", zero_v);

        // Illegal opcode, then NOP, then HALT
        IR = I_ILL;
        fetch("ill");
        cyc("ill_t3", mk(ILL | DONE, 16'h0, 16'h0, 13'h0));
        IR = I_NOP;
        fetch("nop");
        cyc("nop_t3", mk(DONE, 16'h0, 16'h0, 13'h0));
        IR = I_HALT;
        fetch("hlt");
        cyc("hlt_t3", zero_v);
        cyc("halt_a", mk(HALTED, 16'h0, 16'h0, 13'h0));
        Run = 1'b0;
        cyc("halt_run0", mk(HALTED, 16'h0, 16'h0, 13'h0));
        Run = 1'b1;
        cyc("halt_run1", mk(HALTED, 16'h0, 16'h0, 13'h0));

        // Memory never answers: 15 stalled T1 cycles, then HALT with MemTimeout
        Clear = 1'b1;
        cyc("clr2", zero_v);
        Clear = 1'b0;
        MemDone = 1'b0;
        cyc("to_idle", zero_v);
        cyc("to_t0", e_t0);
        for (int i = 0; i < 15; i++)
            cyc($sformatf("to_t1_%0d", i), e_t1);
        cyc("to_halt_a", mk(HALTED | MTO, 16'h0, 16'h0, 13'h0));
        MemDone = 1'b1;
        Run = 1'b0;
        cyc("to_halt_b", mk(HALTED | MTO, 16'h0, 16'h0, 13'h0));
        Clear = 1'b1;
        cyc("clr3", zero_v);

        @(negedge Clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
